// File: rtl/irq_exception_unit.sv
// Exception/interrupt controller beside the ID stage: synchronises and latches IRQ lines,
// arbitrates them against undefined-instruction traps, and tracks kernel mode, EPC and cause.
module irq_exception_unit #(
  parameter int          NUM_IRQ     = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IRQ_VECTOR  = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR  = 32'h80000008
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_raw,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               id_valid,
  input  logic               id_stall,
  input  logic               id_undef,
  input  logic [31:0]        id_pc,
  input  logic               eret,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               kernel_o,
  output logic               exc_req_o,
  output logic [31:0]        exc_vector_o,
  output logic [31:0]        epc_o,
  output logic [4:0]         cause_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam logic [1:0] ST_USER   = 2'd0;
  localparam logic [1:0] ST_TAKE   = 2'd1;
  localparam logic [1:0] ST_KERNEL = 2'd2;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [3:0]         irq_idx;
  logic               irq_hit;
  logic               take;
  logic [1:0]         state_q;
  logic [1:0]         state_d;

  // Metastability chain followed by a rising-edge detector on the last stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      sync_prev <= '0;
    end else begin
      sync_q[0] <= irq_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // A fresh edge on a line outranks its ack landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= (pending_q & ~irq_ack_o) | irq_rise;
      if (mask_wr) begin
        mask_q <= mask_wdata;
      end
    end
  end

  assign eligible   = pending_q & mask_q;
  assign irq_hit    = |eligible;
  assign irq_onehot = eligible & (~eligible + 1'b1);

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_idx = 4'(i);
      end
    end
  end

  assign take = (state_q == ST_USER) && id_valid && !id_stall && (irq_hit || id_undef);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_USER:   if (take) state_d = ST_TAKE;
      ST_TAKE:   state_d = ST_KERNEL;
      ST_KERNEL: if (eret) state_d = ST_USER;
      default:   state_d = ST_USER;
    endcase
  end

  // EPC, cause and vector are captured on the take edge and hold until the next take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_USER;
      exc_vector_o <= '0;
      epc_o        <= '0;
      cause_o      <= '0;
      irq_ack_o    <= '0;
    end else begin
      state_q   <= state_d;
      irq_ack_o <= '0;
      if (take) begin
        if (irq_hit) begin
          exc_vector_o <= IRQ_VECTOR;
          epc_o        <= id_pc;
          cause_o      <= {1'b1, irq_idx};
          irq_ack_o    <= irq_onehot;
        end else begin
          exc_vector_o <= EXC_VECTOR;
          epc_o        <= id_pc + 32'd4;
          cause_o      <= 5'b00000;
        end
      end
    end
  end

  assign mask_o    = mask_q;
  assign pending_o = pending_q;
  assign exc_req_o = (state_q == ST_TAKE);
  assign kernel_o  = (state_q != ST_USER);

endmodule

// File: tb/tb_irq_exception_unit.sv
// Randomised and directed bench for irq_exception_unit: a reference model predicts every
// exception into a scoreboard queue that a negedge monitor drains against the DUT.
module tb_irq_exception_unit;

  localparam int          N  = 4;
  localparam int          S  = 2;
  localparam logic [31:0] IV = 32'h80000004;
  localparam logic [31:0] EV = 32'h80000008;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_raw;
  logic          mask_wr;
  logic [N-1:0]  mask_wdata;
  logic          id_valid;
  logic          id_stall;
  logic          id_undef;
  logic [31:0]   id_pc;
  logic          eret;
  logic [N-1:0]  mask_o;
  logic [N-1:0]  pending_o;
  logic          kernel_o;
  logic          exc_req_o;
  logic [31:0]   exc_vector_o;
  logic [31:0]   epc_o;
  logic [4:0]    cause_o;
  logic [N-1:0]  irq_ack_o;

  irq_exception_unit #(
    .NUM_IRQ(N), .SYNC_STAGES(S), .IRQ_VECTOR(IV), .EXC_VECTOR(EV)
  ) dut (
    .clk(clk), .reset(reset), .irq_raw(irq_raw), .mask_wr(mask_wr),
    .mask_wdata(mask_wdata), .id_valid(id_valid), .id_stall(id_stall),
    .id_undef(id_undef), .id_pc(id_pc), .eret(eret), .mask_o(mask_o),
    .pending_o(pending_o), .kernel_o(kernel_o), .exc_req_o(exc_req_o),
    .exc_vector_o(exc_vector_o), .epc_o(epc_o), .cause_o(cause_o),
    .irq_ack_o(irq_ack_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  vec;
    logic [31:0]  epc;
    logic [4:0]   cause;
    logic [N-1:0] ack;
  } exc_t;

  exc_t sb[$];
  exc_t got;
  int tests = 0;
  int fails = 0;

  // Model state: raw history stands in for the synchroniser delay.
  logic [N-1:0] hist [0:S];
  logic [N-1:0] m_pend, m_mask, m_ack;
  logic         m_kernel, m_take;
  logic [31:0]  m_vec, m_epc;
  logic [4:0]   m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function void model_reset();
    for (int j = 0; j <= S; j++) hist[j] = '0;
    m_pend = '0; m_mask = '0; m_ack = '0;
    m_kernel = 1'b0; m_take = 1'b0;
    m_vec = '0; m_epc = '0; m_cause = '0;
    sb.delete();
  endfunction

  function void model_edge();
    logic [N-1:0] rise, elig, ack_now;
    int idx;
    exc_t e;
    if (reset !== 1'b1) begin
      model_reset();
      return;
    end
    rise = hist[S-1] & ~hist[S];
    for (int j = S; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = irq_raw;
    elig    = m_pend & m_mask;
    ack_now = m_take ? m_ack : '0;
    if (m_take) begin
      m_take = 1'b0;
      m_ack  = '0;
    end else if (m_kernel) begin
      if (eret) m_kernel = 1'b0;
    end else if (id_valid && !id_stall && (elig != '0 || id_undef)) begin
      if (elig != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin idx = i; break; end
        end
        m_vec = IV; m_epc = id_pc; m_cause = {1'b1, 4'(idx)};
        m_ack = '0; m_ack[idx] = 1'b1;
      end else begin
        m_vec = EV; m_epc = id_pc + 32'd4; m_cause = 5'd0; m_ack = '0;
      end
      e.vec = m_vec; e.epc = m_epc; e.cause = m_cause; e.ack = m_ack;
      sb.push_back(e);
      m_take = 1'b1;
      m_kernel = 1'b1;
    end
    m_pend = (m_pend & ~ack_now) | rise;
    if (mask_wr) m_mask = mask_wdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: per-cycle state against the model, and each exc_req_o pulse against the queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("kernel", 32'(kernel_o), 32'(m_kernel));
      check("exc_req", 32'(exc_req_o), 32'(m_take));
      check("pending", 32'(pending_o), 32'(m_pend));
      check("mask", 32'(mask_o), 32'(m_mask));
      check("ack_level", 32'(irq_ack_o), m_take ? 32'(m_ack) : 32'd0);
      check("vector_hold", exc_vector_o, m_vec);
      check("epc_hold", epc_o, m_epc);
      check("cause_hold", 32'(cause_o), 32'(m_cause));
      if (exc_req_o === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_exc: got exc_req_o=1 expected no pending event at %0t", $time);
        end else begin
          got = sb.pop_front();
          check("sb_vector", exc_vector_o, got.vec);
          check("sb_epc", epc_o, got.epc);
          check("sb_cause", 32'(cause_o), 32'(got.cause));
          check("sb_ack", 32'(irq_ack_o), 32'(got.ack));
        end
      end
    end
  end

  initial begin
    irq_raw = '0; mask_wr = 0; mask_wdata = '0; id_valid = 0; id_stall = 0;
    id_undef = 0; id_pc = '0; eret = 0;
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    run(2);
    check("rst_mask", 32'(mask_o), 32'd0);
    check("rst_kernel", 32'(kernel_o), 32'd0);
    check("rst_vector", exc_vector_o, 32'd0);
    reset = 1'b1;

    // Basic IRQ on line 1.
    mask_wr = 1; mask_wdata = 4'b0010; tick();
    mask_wr = 0; irq_raw = 4'b0010; id_valid = 1; id_pc = 32'h00400010; tick();
    irq_raw = '0; tick();
    tick();
    check("d1_pending", 32'(pending_o), 32'h2);
    tick();
    check("d1_req", 32'(exc_req_o), 32'd1);
    check("d1_vec", exc_vector_o, 32'h80000004);
    check("d1_epc", epc_o, 32'h00400010);
    check("d1_cause", 32'(cause_o), 32'h11);
    check("d1_ack", 32'(irq_ack_o), 32'h2);
    tick();
    check("d1_cleared", 32'(pending_o), 32'd0);
    eret = 1; tick();
    check("d1_eret", 32'(kernel_o), 32'd0);
    eret = 0;

    // Masked line stays pending without a take until enabled.
    mask_wr = 1; mask_wdata = '0; tick();
    mask_wr = 0; irq_raw = 4'b0100; run(3);
    check("d2_pending", 32'(pending_o), 32'h4);
    check("d2_noreq", 32'(exc_req_o), 32'd0);
    mask_wr = 1; mask_wdata = 4'b0100; tick();
    mask_wr = 0; tick();
    check("d2_cause", 32'(cause_o), 32'h12);
    irq_raw = '0; tick();
    eret = 1; tick(); eret = 0;

    // Undefined instruction, ignored while in kernel.
    id_undef = 1; id_pc = 32'h00400020; tick();
    check("d3_vec", exc_vector_o, 32'h80000008);
    check("d3_epc", epc_o, 32'h00400024);
    check("d3_cause", 32'(cause_o), 32'd0);
    run(3);
    check("d3_kernel_noreq", 32'(exc_req_o), 32'd0);
    id_undef = 0; eret = 1; tick();
    check("d3_user", 32'(kernel_o), 32'd0);
    eret = 0;

    // Two IRQs plus undef: lowest line first, the other on the first user cycle.
    mask_wr = 1; mask_wdata = 4'b1001; irq_raw = 4'b1001; id_valid = 0; tick();
    mask_wr = 0; run(2);
    id_valid = 1; id_undef = 1; tick();
    check("d4_first", 32'(cause_o), 32'h10);
    tick();
    eret = 1; tick(); eret = 0;
    tick();
    check("d4_second", 32'(cause_o), 32'h13);
    irq_raw = '0; id_undef = 0; tick();
    eret = 1; tick(); eret = 0;

    // New edge on line 1 coinciding with its ack, then a stalled ID stage.
    mask_wr = 1; mask_wdata = 4'b0010; irq_raw = 4'b0010; tick();
    mask_wr = 0; irq_raw = '0; tick();
    irq_raw = 4'b0010; tick();
    tick();
    irq_raw = '0; tick();
    check("d5_set_wins", 32'(pending_o), 32'h2);
    id_stall = 1; eret = 1; tick(); eret = 0;
    run(2);
    check("d5_stalled", 32'(exc_req_o), 32'd0);
    id_stall = 0; tick();
    check("d5_after_stall", 32'(exc_req_o), 32'd1);
    tick();
    eret = 1; tick(); eret = 0;

    // Asynchronous reset while an exception pulse is in flight.
    id_undef = 1; id_pc = 32'h00400100; tick();
    check("d6_req", 32'(exc_req_o), 32'd1);
    id_undef = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("d6_req0", 32'(exc_req_o), 32'd0);
    check("d6_kernel0", 32'(kernel_o), 32'd0);
    check("d6_mask0", 32'(mask_o), 32'd0);
    check("d6_epc0", epc_o, 32'd0);
    check("d6_vec0", exc_vector_o, 32'd0);
    run(2);
    reset = 1'b1;

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) irq_raw[b] = ~irq_raw[b];
      end
      mask_wr    = ($urandom_range(7) == 0);
      mask_wdata = N'($urandom);
      id_valid   = ($urandom_range(3) != 0);
      id_stall   = ($urandom_range(3) == 0);
      id_undef   = ($urandom_range(7) == 0);
      id_pc      = $urandom & 32'hFFFF_FFFC;
      eret       = ($urandom_range(3) == 0);
      tick();
    end

    irq_raw = '0; mask_wr = 0; id_valid = 0; id_undef = 0; eret = 0;
    run(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_exception_unit.md
Name: irq_exception_unit

Overview:
Parametrised sequential exception and interrupt controller for the pipelined MIPS CPU. It replaces the single-wire IRQ and Kernel gating that the control decoder evaluates combinationally. It synchronises NUM_IRQ external interrupt lines, latches and masks them, and arbitrates them against undefined-instruction traps from ID. It tracks kernel mode across cycles and captures EPC/cause. Sits beside the ID stage; drives PC select, flush and the kernel bit back into the decoder.

Parameters:
NUM_IRQ, 4, number of interrupt lines (1..16)
SYNC_STAGES, 2, synchroniser flops per irq line (>=2)
IRQ_VECTOR, 32'h80000004, handler address for interrupts
EXC_VECTOR, 32'h80000008, handler address for undefined instruction

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
irq_raw  in  NUM_IRQ  asynchronous interrupt requests, level
mask_wr  in  1  write strobe for mask register
mask_wdata  in  NUM_IRQ  new mask value (1 = enabled)
id_valid  in  1  ID stage holds a real instruction
id_stall  in  1  ID stage stalled this cycle
id_undef  in  1  decoder flags ID instruction undefined
id_pc  in  32  PC of ID instruction
eret  in  1  return-from-exception retiring (kernel only)
mask_o  out  NUM_IRQ  current mask register
pending_o  out  NUM_IRQ  latched pending interrupts
kernel_o  out  1  CPU in kernel mode
exc_req_o  out  1  one-cycle pulse: flush IF/ID, redirect PC
exc_vector_o  out  32  target PC, valid while exc_req_o
epc_o  out  32  saved return PC
cause_o  out  5  [4]=1 irq / 0 undefined; [3:0]=irq index
irq_ack_o  out  NUM_IRQ  one-hot pulse clearing the taken line

Behaviour:
- Reset (reset=0, async): state USER. Sync chains, edge registers and pending_o = 0; mask_o = 0 (all masked). kernel_o=0, exc_req_o=0, exc_vector_o=0, epc_o=0, cause_o=0, irq_ack_o=0. Reset mid-handler discards everything, including a pulse in flight.
- Sync: each irq_raw bit passes through SYNC_STAGES flops, then a rising-edge detector. A raw rise sampled at edge 0 sets pending at edge SYNC_STAGES.
- Pending: sticky per line. Set on sync rising edge; cleared by irq_ack_o on the same line. Set and ack in the same cycle: set wins (stays pending).
- Mask: written on mask_wr at the clock edge, in any state. Masking never clears pending; it only gates eligibility (pending_o & mask_o).
- FSM states: USER, TAKE, KERNEL.
- USER: a take condition exists when id_valid && !id_stall && (|(pending & mask) || id_undef).
  - On a take condition go to TAKE.
  - IRQ beats undefined. The lowest-index eligible IRQ wins.
  - Registered at that edge:
    - IRQ taken: epc_o=id_pc, cause_o={1,idx}, exc_vector_o=IRQ_VECTOR, irq_ack_o one-hot idx.
    - Undefined taken: epc_o=id_pc+4 (mod 2^32), cause_o=5'b00000, exc_vector_o=EXC_VECTOR.
  - No take condition: stay in USER. eret in USER is ignored.
- TAKE (exactly 1 cycle): exc_req_o=1, kernel_o=1. Next state KERNEL. irq_ack_o is high only during TAKE.
- KERNEL: kernel_o=1. No new exceptions are taken (IRQs keep latching; id_undef ignored). epc_o and cause_o hold.
  - eret=1 moves to USER at the next edge; kernel_o=0 from that edge.
  - Eligible pending IRQs may be taken no earlier than the first USER cycle.
- exc_req_o, irq_ack_o = 0 outside TAKE. exc_vector_o holds its last value.
- Latency: take condition at edge N gives exc_req_o high for cycle N..N+1 and kernel_o high from edge N.

Test Plan:
- Reset then mask_wdata=4'b0010, mask_wr; pulse irq_raw[1] 1 cycle with id_valid=1, id_pc=0x00400010 -> pending_o[1] high 2 edges later; next edge exc_req_o 1 cycle, vector 0x80000004, epc 0x00400010, cause 5'b10001, irq_ack_o=0010, pending cleared.
- Mask=0, raise irq_raw[2] -> pending_o[2]=1, no exc_req_o. Then write mask=4'b0100 -> take on next valid, unstalled ID cycle with cause 5'b10010.
- id_undef=1, id_pc=0x00400020 in USER -> exc_req_o, vector 0x80000008, epc 0x00400024, cause 0. Repeat id_undef while kernel_o=1 -> no pulse. eret -> kernel_o=0 next edge.
- irq[3] and irq[0] pending, both enabled, id_undef=1 simultaneously -> irq 0 taken. After eret, irq 3 taken on the first USER cycle; undefined is not taken while the IRQ wins.
- id_stall=1 with eligible IRQ -> no take until stall drops. New edge on line 1 in the same cycle as its ack -> pending_o[1] stays 1.
- Assert reset during TAKE -> all outputs 0 immediately (async), state USER, mask 0.
